// File: rtl/prog_loader.sv
// Host-to-instruction-memory program loader.
// Receives a length byte, then that many data bytes (0 means 256), written to
// memory starting at BASE_ADDR with mod-256 address wrap. With LOADER_CSUM_EN
// defined, a trailing checksum byte (8-bit sum of the data) is compared and a
// mismatch ends in ERR; without it the last data byte goes straight to DONE.
module prog_loader #(
    parameter logic [7:0] BASE_ADDR = 8'h00
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       mem_we,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_wdata,
    output logic       busy,
    output logic       cpu_hold,
    output logic       done,
    output logic       error,
    output logic [8:0] load_count
);

    localparam int unsigned CNT_W = 9;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LEN  = 3'd1;
    localparam logic [2:0] S_DATA = 3'd2;
    localparam logic [2:0] S_DONE = 3'd4;
`ifdef LOADER_CSUM_EN
    localparam logic [2:0] S_CSUM = 3'd3;
    localparam logic [2:0] S_ERR  = 3'd5;
`endif

    logic [2:0]       state;
    logic [2:0]       state_nx;
    logic [CNT_W-1:0] remaining;
    logic             accept_c;
    logic             start_c;
    logic             last_c;
`ifdef LOADER_CSUM_EN
    logic [7:0]       sum;
`endif

    // Receiving states drive the handshake and the CPU hold directly from state
    always_comb begin
        busy = (state == S_LEN) || (state == S_DATA);
`ifdef LOADER_CSUM_EN
        if (state == S_CSUM) begin
            busy = 1'b1;
        end
`endif
    end

    assign in_ready = busy;
    assign cpu_hold = busy;
    assign accept_c = in_valid && in_ready;
    assign last_c   = (remaining == CNT_W'(1));

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic; start is honoured only in the idle/terminal states
    always_comb begin
        state_nx = state;
        start_c  = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    start_c  = 1'b1;
                    state_nx = S_LEN;
                end
            end
`ifdef LOADER_CSUM_EN
            S_ERR: begin
                if (start) begin
                    start_c  = 1'b1;
                    state_nx = S_LEN;
                end
            end
            S_CSUM: begin
                if (accept_c) begin
                    state_nx = (in_data == sum) ? S_DONE : S_ERR;
                end
            end
`endif
            S_LEN: begin
                if (accept_c) begin
                    state_nx = S_DATA;
                end
            end
            S_DATA: begin
                if (accept_c && last_c) begin
`ifdef LOADER_CSUM_EN
                    state_nx = S_CSUM;
`else
                    state_nx = S_DONE;
`endif
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Datapath: byte counter, write port, status flags
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            remaining  <= '0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            done       <= 1'b0;
            load_count <= '0;
        end else begin
            mem_we <= 1'b0;
            if (start_c) begin
                done       <= 1'b0;
                load_count <= '0;
            end
            if (accept_c && (state == S_LEN)) begin
                remaining <= (in_data == 8'h00) ? CNT_W'(256) : CNT_W'(in_data);
            end
            if (accept_c && (state == S_DATA)) begin
                mem_we     <= 1'b1;
                mem_addr   <= BASE_ADDR + load_count[7:0];
                mem_wdata  <= in_data;
                load_count <= load_count + CNT_W'(1);
                remaining  <= remaining - CNT_W'(1);
`ifndef LOADER_CSUM_EN
                if (last_c) begin
                    done <= 1'b1;
                end
`endif
            end
`ifdef LOADER_CSUM_EN
            if (accept_c && (state == S_CSUM) && (in_data == sum)) begin
                done <= 1'b1;
            end
`endif
        end
    end

`ifdef LOADER_CSUM_EN
    // Running checksum of data bytes and sticky error flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sum   <= '0;
            error <= 1'b0;
        end else begin
            if (start_c) begin
                sum   <= '0;
                error <= 1'b0;
            end
            if (accept_c && (state == S_DATA)) begin
                sum <= sum + in_data;
            end
            if (accept_c && (state == S_CSUM) && (in_data != sum)) begin
                error <= 1'b1;
            end
        end
    end
`else
    assign error = 1'b0;
`endif

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: two instances (BASE_ADDR 00 and F0) share
// one host stream; expected writes are queued per instance when each data byte
// is issued and popped by a monitor whenever mem_we is seen.
module tb_prog_loader;

    logic       clk;
    logic       reset;
    logic       start;
    logic       in_valid;
    logic [7:0] in_data;

    logic       d0_in_ready, d0_mem_we, d0_busy, d0_cpu_hold, d0_done, d0_error;
    logic [7:0] d0_mem_addr, d0_mem_wdata;
    logic [8:0] d0_load_count;
    logic       d1_in_ready, d1_mem_we, d1_busy, d1_cpu_hold, d1_done, d1_error;
    logic [7:0] d1_mem_addr, d1_mem_wdata;
    logic [8:0] d1_load_count;

    int checks;
    int errors;

    logic [15:0] q0[$];
    logic [15:0] q1[$];
    logic [7:0]  mem0[256];
    logic [7:0]  mem1[256];

    prog_loader #(.BASE_ADDR(8'h00)) dut0 (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(d0_in_ready), .mem_we(d0_mem_we), .mem_addr(d0_mem_addr),
        .mem_wdata(d0_mem_wdata), .busy(d0_busy), .cpu_hold(d0_cpu_hold),
        .done(d0_done), .error(d0_error), .load_count(d0_load_count)
    );

    prog_loader #(.BASE_ADDR(8'hF0)) dut1 (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(d1_in_ready), .mem_we(d1_mem_we), .mem_addr(d1_mem_addr),
        .mem_wdata(d1_mem_wdata), .busy(d1_busy), .cpu_hold(d1_cpu_hold),
        .done(d1_done), .error(d1_error), .load_count(d1_load_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h required %0h", name, act, exp);
        end
    endtask

    // Pops expected writes for both instances whenever a strobe is seen
    task automatic monitor();
        logic [15:0] e;
        forever begin
            @(negedge clk);
            if (d0_mem_we) begin
                checks++;
                if (q0.size() == 0) begin
                    errors++;
                    $display("FAIL dut0 unexpected write actual %0h<-%0h required none",
                             d0_mem_addr, d0_mem_wdata);
                end else begin
                    e = q0.pop_front();
                    if ({d0_mem_addr, d0_mem_wdata} !== e) begin
                        errors++;
                        $display("FAIL dut0 write actual %0h<-%0h required %0h<-%0h",
                                 d0_mem_addr, d0_mem_wdata, e[15:8], e[7:0]);
                    end
                end
                mem0[d0_mem_addr] = d0_mem_wdata;
            end
            if (d1_mem_we) begin
                checks++;
                if (q1.size() == 0) begin
                    errors++;
                    $display("FAIL dut1 unexpected write actual %0h<-%0h required none",
                             d1_mem_addr, d1_mem_wdata);
                end else begin
                    e = q1.pop_front();
                    if ({d1_mem_addr, d1_mem_wdata} !== e) begin
                        errors++;
                        $display("FAIL dut1 write actual %0h<-%0h required %0h<-%0h",
                                 d1_mem_addr, d1_mem_wdata, e[15:8], e[7:0]);
                    end
                end
                mem1[d1_mem_addr] = d1_mem_wdata;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Presents a byte and waits (bounded) for it to be accepted; in_valid stays high
    task automatic send(input logic [7:0] b);
        int n;
        in_valid = 1'b1;
        in_data  = b;
        n = 0;
        while (!d0_in_ready && n < 50) begin
            tick();
            n++;
        end
        if (!d0_in_ready) begin
            checks++;
            errors++;
            $display("FAIL send timeout actual in_ready=0 required 1");
        end else begin
            tick();
        end
    endtask

    task automatic send_data(input logic [7:0] idx, input logic [7:0] b);
        logic [7:0] a0;
        logic [7:0] a1;
        a0 = 8'h00 + idx;
        a1 = 8'hF0 + idx;
        q0.push_back({a0, b});
        q1.push_back({a1, b});
        send(b);
    endtask

    task automatic drain();
        in_valid = 1'b0;
        tick();
        tick();
        chk("queue0 drained", 32'(q0.size()), 32'd0);
        chk("queue1 drained", 32'(q1.size()), 32'd0);
    endtask

    initial begin
        logic [7:0] s;
        checks   = 0;
        errors   = 0;
        reset    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        for (int i = 0; i < 256; i++) begin
            mem0[i] = 8'h00;
            mem1[i] = 8'h00;
        end
        fork
            monitor();
        join_none

        // Reset state
        #2;
        chk("reset outputs", {d0_in_ready, d0_mem_we, d0_busy, d0_cpu_hold, d0_done, d0_error},
            32'd0);
        chk("reset addr/data/count", {d0_mem_addr, d0_mem_wdata, 7'd0, d0_load_count}, 32'd0);
        tick();
        tick();
        reset = 1'b1;
        tick();
        chk("idle in_ready", 32'(d0_in_ready), 32'd0);

        // Clean load 03,11,22,33 (+66)
        do_start();
        chk("busy after start", {d0_busy, d0_cpu_hold, d0_in_ready}, 32'h7);
        send(8'h03);
        send_data(8'd0, 8'h11);
        send_data(8'd1, 8'h22);
        send_data(8'd2, 8'h33);
`ifdef LOADER_CSUM_EN
        chk("busy in csum", 32'(d0_busy), 32'd1);
        send(8'h66);
`endif
        chk("clean done/error", {d0_done, d0_error, d1_done}, 32'h5);
        chk("clean load_count", 32'(d0_load_count), 32'd3);
        chk("clean idle ready", {d0_in_ready, d0_busy}, 32'd0);
        drain();

`ifdef LOADER_CSUM_EN
        // Bad checksum 02,AA,55,00
        do_start();
        chk("restart clears", {d0_done, 7'd0, d0_load_count}, 32'd0);
        send(8'h02);
        send_data(8'd0, 8'hAA);
        send_data(8'd1, 8'h55);
        send(8'h00);
        chk("badcsum error/done", {d0_error, d0_done, d0_in_ready, d0_busy}, 32'h8);
        chk("badcsum load_count", 32'(d0_load_count), 32'd2);
        drain();
`else
        // Single byte load 01,7E; done on the cycle after the data accept
        do_start();
        chk("restart clears", {d0_done, 7'd0, d0_load_count}, 32'd0);
        send(8'h01);
        send_data(8'd0, 8'h7E);
        chk("nocsum done/error", {d0_done, d0_error}, 32'h2);
        chk("nocsum load_count", 32'(d0_load_count), 32'd1);
        drain();
`endif

        // Stall with in_valid gaps and a mid-load start pulse
        do_start();
        send(8'h03);
        send_data(8'd0, 8'h01);
        in_valid = 1'b0;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        tick();
        chk("stall count held", 32'(d0_load_count), 32'd1);
        chk("stall busy", {d0_busy, d0_in_ready, d0_done}, 32'h6);
        send_data(8'd1, 8'h02);
        send_data(8'd2, 8'h03);
`ifdef LOADER_CSUM_EN
        send(8'h06);
`endif
        chk("stall done", 32'(d0_done), 32'd1);
        chk("stall load_count", 32'(d0_load_count), 32'd3);
        drain();

        // Length 0 = 256 bytes, address wrap on the F0 instance
        do_start();
        send(8'h00);
        s = 8'h00;
        for (int i = 0; i < 256; i++) begin
            s = s + (8'(i) ^ 8'h5A);
            send_data(8'(i), 8'(i) ^ 8'h5A);
        end
`ifdef LOADER_CSUM_EN
        send(s);
`endif
        chk("len0 load_count", 32'(d0_load_count), 32'd256);
        chk("len0 done", {d0_done, d1_done, d1_error}, 32'h6);
        drain();
        chk("wrap mem1[EF]", 32'(mem1[8'hEF]), 32'hA5);
        chk("wrap mem1[00]", 32'(mem1[8'h00]), 32'h4A);
        chk("wrap mem1[F0]", 32'(mem1[8'hF0]), 32'h5A);

        // Reset after 2 of 5 data bytes
        do_start();
        send(8'h05);
        send_data(8'd0, 8'hA1);
        send_data(8'd1, 8'hA2);
        in_valid = 1'b0;
        @(negedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("midreset flags", {d0_in_ready, d0_mem_we, d0_busy, d0_cpu_hold, d0_done, d0_error},
            32'd0);
        chk("midreset addr/data/count", {d0_mem_addr, d0_mem_wdata, 7'd0, d0_load_count}, 32'd0);
        tick();
        tick();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("post-reset in_ready", {d0_in_ready, d0_mem_we}, 32'd0);
        end
        chk("kept mem0[00]", 32'(mem0[8'h00]), 32'hA1);
        chk("kept mem0[01]", 32'(mem0[8'h01]), 32'hA2);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
